// File: rtl/cpu_data_pkg.sv
// Shared definitions for the interrupt controller: IRQ count, register
// offsets, FSM state encoding and a lowest-set-bit helper.
package cpu_data_pkg;

  localparam int unsigned NUM_IRQ = 8;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned OFF_W   = 2;
  localparam int unsigned NUM_REG = 4;

  localparam logic [OFF_W-1:0] OFF_PENDING    = 2'd0;
  localparam logic [OFF_W-1:0] OFF_MASK       = 2'd1;
  localparam logic [OFF_W-1:0] OFF_IN_SERVICE = 2'd2;
  localparam logic [OFF_W-1:0] OFF_EOI        = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } irq_state_e;

  // Isolates the lowest-index (highest-priority) set bit.
  function automatic logic [NUM_IRQ-1:0] lowest_set(input logic [NUM_IRQ-1:0] v);
    return v & (~v + NUM_IRQ'(1));
  endfunction

endpackage

// File: rtl/irq_priority.sv
// Fixed-priority encoder: bit 0 wins; one-hot grant plus valid.
module irq_priority
  import cpu_data_pkg::*;
(
  input  logic [NUM_IRQ-1:0] i_req,
  output logic [NUM_IRQ-1:0] o_grant_c,
  output logic               o_valid_c
);

  assign o_grant_c = lowest_set(i_req);
  assign o_valid_c = |i_req;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped 8-line interrupt controller with nesting and EOI.
// Define IRQ_EDGE_DETECT_EN for latched rising-edge PENDING; default is level.
module irq_controller
  import cpu_data_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq_lines,
  input  logic [ADDR_W-1:0]   address_bus,
  input  logic                r,
  input  logic                w,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   data_out,
  output logic                hit,
  input  logic                irq_ack,
  output logic [NUM_IRQ-1:0]  interrupts
);

  logic [NUM_IRQ-1:0] r_sync1;
  logic [NUM_IRQ-1:0] r_sync2;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] r_in_service;
  logic [NUM_IRQ-1:0] r_interrupts;
  irq_state_e         r_state;

  logic [ADDR_W-1:0]  w_off_full;
  logic [OFF_W-1:0]   w_off;
  logic               w_wr;
  logic [NUM_IRQ-1:0] w_wdata;
  logic [NUM_IRQ-1:0] w_eoi_clr;
  logic [NUM_IRQ-1:0] w_isr_top;
  logic [NUM_IRQ-1:0] w_prio_win;
  logic [NUM_IRQ-1:0] w_eligible;
  logic [NUM_IRQ-1:0] w_grant;
  logic               w_grant_valid;
  logic [NUM_IRQ-1:0] w_ack_set;
  logic [NUM_IRQ-1:0] w_rd_reg;
  logic               w_ack_fire;
  irq_state_e         w_state_nxt;
  logic [NUM_IRQ-1:0] w_int_nxt;
  logic               w_unused_data;

  // Address decode; subtraction keeps the window correct near the top of memory.
  assign w_off_full    = address_bus - BASE_ADDR;
  assign hit           = (w_off_full < ADDR_W'(NUM_REG));
  assign w_off         = w_off_full[OFF_W-1:0];
  assign w_wr          = w & hit;
  assign w_wdata       = data_in[NUM_IRQ-1:0];
  assign w_unused_data = ^data_in[DATA_W-1:NUM_IRQ];
  assign w_eoi_clr     = (w_wr && (w_off == OFF_EOI)) ? w_wdata : '0;

  // Only requests above the highest-priority in-service level may be raised.
  assign w_isr_top  = lowest_set(r_in_service);
  assign w_prio_win = (r_in_service == '0) ? '1 : (w_isr_top - NUM_IRQ'(1));
  assign w_eligible = r_pending & r_mask & w_prio_win;
  assign w_ack_set  = w_ack_fire ? r_interrupts : '0;

  irq_priority u_prio (
    .i_req     (w_eligible),
    .o_grant_c (w_grant),
    .o_valid_c (w_grant_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_lines;
      r_sync2 <= r_sync1;
    end
  end

`ifdef IRQ_EDGE_DETECT_EN
  logic [NUM_IRQ-1:0] r_sync3;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_pend_clr;

  assign w_rise     = r_sync2 & ~r_sync3;
  assign w_pend_clr = ((w_wr && (w_off == OFF_PENDING)) ? w_wdata : '0) | w_ack_set;

  // A new edge on the same cycle as a clear keeps the bit set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync3   <= '0;
      r_pending <= '0;
    end else begin
      r_sync3   <= r_sync2;
      r_pending <= (r_pending & ~w_pend_clr) | w_rise;
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= r_sync2;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mask       <= '0;
      r_in_service <= '0;
    end else begin
      if (w_wr && (w_off == OFF_MASK)) begin
        r_mask <= w_wdata;
      end
      r_in_service <= (r_in_service & ~w_eoi_clr) | w_ack_set;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_interrupts <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_interrupts <= w_int_nxt;
    end
  end

  // Request FSM: ack takes precedence over a same-cycle loss of eligibility.
  always_comb begin
    w_state_nxt = r_state;
    w_int_nxt   = r_interrupts;
    w_ack_fire  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_int_nxt = '0;
        if (w_grant_valid) begin
          w_state_nxt = ST_REQ;
          w_int_nxt   = w_grant;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          w_ack_fire  = 1'b1;
          w_state_nxt = ST_IDLE;
          w_int_nxt   = '0;
        end else if ((r_interrupts & w_eligible) == '0) begin
          w_state_nxt = ST_IDLE;
          w_int_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_int_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_rd_reg = '0;
    case (w_off)
      OFF_PENDING:    w_rd_reg = r_pending;
      OFF_MASK:       w_rd_reg = r_mask;
      OFF_IN_SERVICE: w_rd_reg = r_in_service;
      default:        w_rd_reg = '0;
    endcase
  end

  assign data_out   = (r && hit) ? {(DATA_W-NUM_IRQ)'(0), w_rd_reg} : '0;
  assign interrupts = r_interrupts;

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The parameter BASE_ADDR SHALL default to 16'hFF00 and SHALL be the address of the first of four consecutive word registers.
REQ-002 The port clk SHALL be an input, 1 bit wide, and the single clock; all state updates on its rising edge.
REQ-003 The port reset SHALL be an input, 1 bit wide, asynchronous and active-low (0 = reset).
REQ-004 The port irq_lines SHALL be an input, 8 bits wide, asynchronous device request lines, bit 0 = highest priority.
REQ-005 The port address_bus SHALL be an input, 16 bits wide, the CPU address.
REQ-006 The ports r and w SHALL be inputs, 1 bit each, the CPU read and write strobes.
REQ-007 The port data_in SHALL be an input, 16 bits wide, the CPU write data (low byte used).
REQ-008 The port data_out SHALL be an output, 16 bits wide, the read data.
REQ-009 The port hit SHALL be an output, 1 bit wide, high when address_bus is in BASE_ADDR..BASE_ADDR+3.
REQ-010 The port irq_ack SHALL be an input, 1 bit wide, a one-cycle pulse from the CPU accepting the presented interrupt.
REQ-011 The port interrupts SHALL be an output, 8 bits wide, one-hot registered request to the CPU interrupts input.

Function
REQ-012 Each irq_lines bit SHALL pass through a 2-flop synchronizer before any use.
REQ-013 Register map: +0 PENDING (read; write-1-to-clear), +1 MASK (read/write, 1 = enabled), +2 IN_SERVICE (read-only), +3 EOI (write: bit set clears that IN_SERVICE bit; reads 0).
REQ-014 Reads SHALL be combinational: when r is high and hit is high, data_out = {8'h00, reg}; otherwise data_out = 16'h0000.
REQ-015 Writes SHALL take effect on the rising edge with w high and hit high; writes to +2 SHALL be ignored.
REQ-016 Eligible set = PENDING & MASK, restricted to bits of strictly higher priority than the highest-priority IN_SERVICE bit (all bits when IN_SERVICE = 0).
REQ-017 The FSM SHALL have the states IDLE and REQ.
REQ-018 In IDLE with eligible non-zero, the FSM SHALL go to REQ and latch interrupts = one-hot of the lowest-index eligible bit.
REQ-019 In REQ, interrupts SHALL be held stable until irq_ack.
REQ-020 On irq_ack in REQ, the block SHALL clear that PENDING bit, set that IN_SERVICE bit, zero interrupts and return to IDLE on the same edge.
REQ-021 If the requested bit becomes ineligible while in REQ (mask write, W1C, or higher in-service), the block SHALL zero interrupts and go to IDLE on the next edge; a higher-priority arrival SHALL NOT preempt an outstanding REQ.
REQ-022 irq_ack in IDLE SHALL be ignored.
REQ-023 Latency: a line high from edge N SHALL set PENDING at edge N+2 and assert interrupts at edge N+3 (IDLE, enabled, eligible).
REQ-024 When a set and a clear of a PENDING bit occur on the same edge (W1C or irq_ack), the set SHALL win.
REQ-025 EOI of a bit not in service SHALL have no effect.

Reset
REQ-026 While reset = 0: synchronizers, PENDING, MASK and IN_SERVICE SHALL be 8'h00, interrupts SHALL be 8'h00, and the FSM SHALL be in IDLE.
REQ-027 Reset SHALL abort a REQ immediately, without needing a clock edge.

Configuration
REQ-028 With IRQ_EDGE_DETECT_EN defined, PENDING bits SHALL set on a synchronized 0->1 transition and stay set until cleared.
REQ-029 Without IRQ_EDGE_DETECT_EN, PENDING SHALL equal the synchronized level each cycle, and W1C writes to +0 SHALL be ignored.

Structure
REQ-030 Register offsets, FSM state encodings and the IRQ count (8) SHALL be defined in the shared cpu_data definitions.
REQ-031 The priority encoder SHALL be a sub-module named irq_priority (8-bit in, one-hot out plus valid).

Verification
REQ-032 Edge build: MASK=8'h01, pulse irq_lines[0] -> interrupts=8'h01 three edges later; irq_ack -> interrupts=0, IN_SERVICE=8'h01, PENDING=0.
REQ-033 Lines 3 and 5 rise together with MASK=8'hFF -> interrupts=8'h08; after ack, 5 stays pending and blocked; EOI 8'h08 -> interrupts=8'h20.
REQ-034 IN_SERVICE=8'h04, line 1 rises -> interrupts=8'h02 (nesting); line 6 rises -> no request.
REQ-035 In REQ on bit 2, write MASK=8'h00 -> interrupts=0 next edge, FSM IDLE, PENDING[2] still 1.
REQ-036 Edge on bit 4 on the same edge as W1C of 8'h10 -> PENDING[4]=1.
REQ-037 Drive reset low mid-REQ -> interrupts=0 asynchronously, all registers read 0; read of BASE_ADDR+4 -> hit=0, data_out=16'h0000.
